regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//  Shares the register file's two write ports (wr1/wr2) between N_REQ write
//  sources (ALU, load unit, move unit, ...). Grants up to two writes per cycle
//  with round-robin fairness, never grants two writes to the same register in
//  one cycle, and registers the winners onto the regfile write ports.
//  Exposes a per-register pending mask for read-side hazard stalls.
// PARAMETERS
//  N_REQ   4   number of write requesters, legal range 2..8
//  AW      2   register address width (4 registers)
//  DW      16  register data width
// PORTS
//  clock       in   1         rising-edge clock
//  reset       in   1         asynchronous, active-high reset
//  stall       in   1         1 = grant nothing this cycle
//  req_valid   in   N_REQ     requester i has a write pending
//  req_addr    in   AW*N_REQ  requester i target register, bits [AW*i+:AW]
//  req_data    in   DW*N_REQ  requester i write data, bits [DW*i+:DW]
//  req_ready   out  N_REQ     requester i is accepted this cycle (valid&ready)
//  wr1         out  AW        regfile write port 1 address (registered)
//  wr1_data    out  DW        regfile write port 1 data (registered)
//  wr1_enable  out  1         regfile write port 1 enable (registered)
//  wr2         out  AW        regfile write port 2 address (registered)
//  wr2_data    out  DW        regfile write port 2 data (registered)
//  wr2_enable  out  1         regfile write port 2 enable (registered)
//  reg_pending out  2**AW     bit r = 1: write to r is on a port, not yet in regfile
// BEHAVIOUR
//  - Reset (async): wr1/wr2/wr*_data = 0, wr*_enable = 0, rr_ptr = 0.
//    req_ready forced to 0 while reset is high. Writes already accepted but
//    not yet committed are dropped.
//  - Grant, combinational each cycle (no grants if stall or reset):
//    scan i = rr_ptr, rr_ptr+1, ... mod N_REQ, one full pass.
//    slot A = first i with req_valid. slot B = next i after A with req_valid
//    and req_addr[i] != req_addr[A]. Requesters that match A's address,
//    or come after B, are not granted this cycle.
//  - req_ready[i] = 1 iff i is slot A or slot B. It depends only on
//    req_valid/req_addr/stall/rr_ptr, never on req_ready (no loop).
//  - Requester contract: once valid is high, hold valid/addr/data stable
//    until ready is seen. Dropping valid earlier is illegal; the bench flags it.
//  - Edge after grant (latency 1): slot A -> wr1, wr1_data, wr1_enable = 1.
//    slot B -> wr2, wr2_data, wr2_enable = 1. An empty slot drives its enable
//    to 0 and holds its addr/data.
//  - The regfile commits on the following edge, so accept-to-visible is 2 clocks.
//  - wr1 and wr2 never carry the same address with both enables high, so the
//    regfile's port-order overwrite rule is never exercised.
//  - rr_ptr <= (index of last granted slot + 1) mod N_REQ.
//    Unchanged when nothing is granted, including when stall is high.
//  - reg_pending[r] = (wr1_enable & wr1==r) | (wr2_enable & wr2==r).
//    Decoded from the registered outputs only.
//  - Same requester is granted at most once per cycle. Wrap-around: with
//    rr_ptr = N_REQ-1, the scan continues at 0.
//  - stall asserted: next edge drives both enables to 0. rr_ptr holds.
//    Pending requests wait.
// TESTING
//  1 reset mid-stream: wr1_enable=1 at reset assert -> all outputs 0
//    immediately, rr_ptr=0, req_ready=0 until reset falls.
//  2 req_valid=4'b0101, addr0=1, addr2=3, rr_ptr=0 -> ready=0101;
//    next cycle wr1=1, wr2=3, both enables 1; reg_pending=4'b1010.
//  3 same-address conflict: valid=0011, addr0=addr1=2 -> ready=0001,
//    wr1=2, wr2_enable=0; next cycle ready=0010, wr1=2 with req1 data.
//  4 fairness: all four valid, distinct addrs, held -> grant pairs
//    {0,1},{2,3},{0,1}; rr_ptr sequence 0,2,0.
//  5 wrap: rr_ptr=3, valid=1001 -> slot A=3 on wr1, slot B=0 on wr2;
//    rr_ptr becomes 1.
//  6 stall=1 for 3 cycles with valid=1111 -> ready=0, enables 0 after
//    1 cycle, rr_ptr unchanged; stall=0 -> grants resume from held rr_ptr.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// Requester and regfile-write-port bundle for regfile_write_arbiter.
// The arbiter takes the slave modport; requesters and the regfile side take master.
interface regfile_write_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned AW    = 2,
    parameter int unsigned DW    = 16
);
    logic                  stall;
    logic [N_REQ-1:0]      req_valid;
    logic [AW*N_REQ-1:0]   req_addr;
    logic [DW*N_REQ-1:0]   req_data;
    logic [N_REQ-1:0]      req_ready;

    logic [AW-1:0]         wr1;
    logic [DW-1:0]         wr1_data;
    logic                  wr1_enable;
    logic [AW-1:0]         wr2;
    logic [DW-1:0]         wr2_data;
    logic                  wr2_enable;
    logic [(2**AW)-1:0]    reg_pending;

    modport master (
        output stall, req_valid, req_addr, req_data,
        input  req_ready,
        input  wr1, wr1_data, wr1_enable,
        input  wr2, wr2_data, wr2_enable,
        input  reg_pending
    );

    modport slave (
        input  stall, req_valid, req_addr, req_data,
        output req_ready,
        output wr1, wr1_data, wr1_enable,
        output wr2, wr2_data, wr2_enable,
        output reg_pending
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter granting up to two non-conflicting register writes per cycle
// and registering the winners onto the two regfile write ports.
module regfile_write_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned AW    = 2,
    parameter int unsigned DW    = 16
) (
    input logic                   clock,
    input logic                   reset,
    regfile_write_arbiter_if.slave bus
);
    localparam int unsigned PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned NREG = 2 ** AW;

    logic [PW-1:0]    rr_q, rr_d;
    logic             a_found, b_found;
    logic [PW-1:0]    a_idx, b_idx;
    logic [AW-1:0]    a_addr, b_addr;
    logic [DW-1:0]    a_data, b_data;
    logic [N_REQ-1:0] ready;

    logic [AW-1:0]    wr1_q, wr2_q;
    logic [DW-1:0]    wr1_data_q, wr2_data_q;
    logic             wr1_en_q, wr2_en_q;
    logic [NREG-1:0]  pending;

    // Position k steps after base in the circular requester order.
    function automatic logic [PW-1:0] scan_idx(input logic [PW-1:0] base,
                                               input int unsigned k);
        int unsigned s;
        s = 32'(base) + k;
        if (s >= N_REQ) s = s - N_REQ;
        return PW'(s);
    endfunction

    always_comb begin : grant_scan
        logic [PW-1:0] idx;
        idx     = '0;
        a_found = 1'b0;
        b_found = 1'b0;
        a_idx   = '0;
        b_idx   = '0;
        a_addr  = '0;
        if (!bus.stall && !reset) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                idx = scan_idx(rr_q, k);
                if (bus.req_valid[idx]) begin
                    if (!a_found) begin
                        a_found = 1'b1;
                        a_idx   = idx;
                        a_addr  = bus.req_addr[AW*idx +: AW];
                    end else if (!b_found && (bus.req_addr[AW*idx +: AW] != a_addr)) begin
                        b_found = 1'b1;
                        b_idx   = idx;
                    end
                end
            end
        end
    end

    always_comb begin
        a_data = bus.req_data[DW*a_idx +: DW];
        b_addr = bus.req_addr[AW*b_idx +: AW];
        b_data = bus.req_data[DW*b_idx +: DW];
    end

    always_comb begin
        ready = '0;
        if (a_found) ready[a_idx] = 1'b1;
        if (b_found) ready[b_idx] = 1'b1;
    end

    // Pointer moves just past the last slot granted; holds when nothing is granted.
    always_comb begin
        rr_d = rr_q;
        if (b_found) begin
            rr_d = scan_idx(b_idx, 1);
        end else if (a_found) begin
            rr_d = scan_idx(a_idx, 1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_q       <= '0;
            wr1_q      <= '0;
            wr1_data_q <= '0;
            wr1_en_q   <= 1'b0;
            wr2_q      <= '0;
            wr2_data_q <= '0;
            wr2_en_q   <= 1'b0;
        end else begin
            rr_q     <= rr_d;
            wr1_en_q <= a_found;
            wr2_en_q <= b_found;
            if (a_found) begin
                wr1_q      <= a_addr;
                wr1_data_q <= a_data;
            end
            if (b_found) begin
                wr2_q      <= b_addr;
                wr2_data_q <= b_data;
            end
        end
    end

    always_comb begin
        pending = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            if (wr1_en_q && (wr1_q == AW'(r))) pending[r] = 1'b1;
            if (wr2_en_q && (wr2_q == AW'(r))) pending[r] = 1'b1;
        end
    end

    assign bus.req_ready   = ready;
    assign bus.wr1         = wr1_q;
    assign bus.wr1_data    = wr1_data_q;
    assign bus.wr1_enable  = wr1_en_q;
    assign bus.wr2         = wr2_q;
    assign bus.wr2_data    = wr2_data_q;
    assign bus.wr2_enable  = wr2_en_q;
    assign bus.reg_pending = pending;

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(wr1_en_q && wr2_en_q && (wr1_q == wr2_q)))
                else $error("both write ports target register %0d", wr1_q);
        end
    end
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed scenarios plus randomized traffic against a queue-based grant model.
module tb_regfile_write_arbiter;
    localparam int N  = 4;
    localparam int AW = 2;
    localparam int DW = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic          r_valid [N];
    logic [AW-1:0] r_addr  [N];
    logic [DW-1:0] r_data  [N];

    int            m_rr;
    logic          e_en1, e_en2;
    logic [AW-1:0] e_wr1, e_wr2;
    logic [DW-1:0] e_d1, e_d2;

    always #5 clock = ~clock;

    regfile_write_arbiter_if #(.N_REQ(N), .AW(AW), .DW(DW)) bus ();

    regfile_write_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]           = r_valid[i];
            bus.req_addr[AW*i +: AW]   = r_addr[i];
            bus.req_data[DW*i +: DW]   = r_data[i];
        end
    endtask

    task automatic set_valid(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) r_valid[i] = v[i];
        drive();
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        bus.stall = 1'b0;
        for (int i = 0; i < N; i++) begin
            r_valid[i] = 1'b0;
            r_addr[i]  = '0;
            r_data[i]  = '0;
        end
        drive();
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        r_addr[0] = 2'd2;
        r_data[0] = 16'hA5A5;
        set_valid(4'b0001);
        tick();
        checks++; if ({bus.wr1_enable, bus.wr1} !== {1'b1, 2'd2}) begin
            errors++; $display("FAIL rst_pre_wr1 got %b want %b", {bus.wr1_enable, bus.wr1}, 3'b110); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if ({bus.wr1_enable, bus.wr1, bus.wr1_data} !== 19'd0) begin
            errors++; $display("FAIL rst_async_wr1 got %h want 0", {bus.wr1_enable, bus.wr1, bus.wr1_data}); end
        checks++; if (bus.reg_pending !== 4'b0000) begin
            errors++; $display("FAIL rst_pending got %b want 0000", bus.reg_pending); end
        checks++; if (bus.req_ready !== 4'b0000) begin
            errors++; $display("FAIL rst_ready got %b want 0000", bus.req_ready); end
        tick();
        checks++; if ({bus.req_ready, bus.wr1_enable, bus.wr2_enable} !== 6'd0) begin
            errors++; $display("FAIL rst_hold got %b want 000000", {bus.req_ready, bus.wr1_enable, bus.wr2_enable}); end
        reset = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin
            errors++; $display("FAIL rst_release_ready got %b want 0001", bus.req_ready); end
        tick();
        checks++; if ({bus.wr1_enable, bus.wr1, bus.wr1_data} !== {1'b1, 2'd2, 16'hA5A5}) begin
            errors++; $display("FAIL rst_after_wr1 got %h want %h", {bus.wr1_enable, bus.wr1, bus.wr1_data}, {1'b1, 2'd2, 16'hA5A5}); end
        set_valid(4'b0000);
    endtask

    task automatic test_two_writes();
        do_reset();
        r_addr[0] = 2'd1; r_data[0] = 16'h1111;
        r_addr[2] = 2'd3; r_data[2] = 16'h3333;
        set_valid(4'b0101);
        #1;
        checks++; if (bus.req_ready !== 4'b0101) begin
            errors++; $display("FAIL two_ready got %b want 0101", bus.req_ready); end
        tick();
        set_valid(4'b0000);
        checks++; if ({bus.wr1_enable, bus.wr1, bus.wr1_data} !== {1'b1, 2'd1, 16'h1111}) begin
            errors++; $display("FAIL two_wr1 got %h want %h", {bus.wr1_enable, bus.wr1, bus.wr1_data}, {1'b1, 2'd1, 16'h1111}); end
        checks++; if ({bus.wr2_enable, bus.wr2, bus.wr2_data} !== {1'b1, 2'd3, 16'h3333}) begin
            errors++; $display("FAIL two_wr2 got %h want %h", {bus.wr2_enable, bus.wr2, bus.wr2_data}, {1'b1, 2'd3, 16'h3333}); end
        checks++; if (bus.reg_pending !== 4'b1010) begin
            errors++; $display("FAIL two_pending got %b want 1010", bus.reg_pending); end
        tick();
        checks++; if ({bus.wr1_enable, bus.wr2_enable, bus.wr1, bus.wr2, bus.reg_pending} !== {1'b0, 1'b0, 2'd1, 2'd3, 4'b0000}) begin
            errors++; $display("FAIL two_idle_hold got %b want %b", {bus.wr1_enable, bus.wr2_enable, bus.wr1, bus.wr2, bus.reg_pending}, 10'b0001110000); end
    endtask

    task automatic test_conflict();
        do_reset();
        r_addr[0] = 2'd2; r_data[0] = 16'hAAAA;
        r_addr[1] = 2'd2; r_data[1] = 16'hBBBB;
        set_valid(4'b0011);
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin
            errors++; $display("FAIL conf_ready1 got %b want 0001", bus.req_ready); end
        tick();
        set_valid(4'b0010);
        checks++; if ({bus.wr1_enable, bus.wr1, bus.wr1_data, bus.wr2_enable} !== {1'b1, 2'd2, 16'hAAAA, 1'b0}) begin
            errors++; $display("FAIL conf_wr_first got %h want %h", {bus.wr1_enable, bus.wr1, bus.wr1_data, bus.wr2_enable}, {1'b1, 2'd2, 16'hAAAA, 1'b0}); end
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin
            errors++; $display("FAIL conf_ready2 got %b want 0010", bus.req_ready); end
        tick();
        set_valid(4'b0000);
        checks++; if ({bus.wr1_enable, bus.wr1, bus.wr1_data, bus.wr2_enable} !== {1'b1, 2'd2, 16'hBBBB, 1'b0}) begin
            errors++; $display("FAIL conf_wr_second got %h want %h", {bus.wr1_enable, bus.wr1, bus.wr1_data, bus.wr2_enable}, {1'b1, 2'd2, 16'hBBBB, 1'b0}); end
    endtask

    task automatic test_fairness();
        logic [N-1:0] exp_ready [3];
        int           exp_a [3];
        int           exp_b [3];
        exp_ready[0] = 4'b0011; exp_a[0] = 0; exp_b[0] = 1;
        exp_ready[1] = 4'b1100; exp_a[1] = 2; exp_b[1] = 3;
        exp_ready[2] = 4'b0011; exp_a[2] = 0; exp_b[2] = 1;
        do_reset();
        for (int i = 0; i < N; i++) begin
            r_addr[i] = AW'(i);
            r_data[i] = 16'h0100 * DW'(i + 1);
        end
        set_valid(4'b1111);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (bus.req_ready !== exp_ready[c]) begin
                errors++; $display("FAIL fair_ready[%0d] got %b want %b", c, bus.req_ready, exp_ready[c]); end
            tick();
            checks++; if ({bus.wr1, bus.wr1_data, bus.wr2, bus.wr2_data} !== {r_addr[exp_a[c]], r_data[exp_a[c]], r_addr[exp_b[c]], r_data[exp_b[c]]}) begin
                errors++; $display("FAIL fair_ports[%0d] got %h want %h", c, {bus.wr1, bus.wr1_data, bus.wr2, bus.wr2_data}, {r_addr[exp_a[c]], r_data[exp_a[c]], r_addr[exp_b[c]], r_data[exp_b[c]]}); end
        end
        set_valid(4'b0000);
    endtask

    task automatic test_wrap();
        do_reset();
        r_addr[2] = 2'd1; r_data[2] = 16'h2222;
        set_valid(4'b0100);
        tick();
        r_addr[0] = 2'd0; r_data[0] = 16'h0A0A;
        r_addr[3] = 2'd3; r_data[3] = 16'h3B3B;
        set_valid(4'b1001);
        #1;
        checks++; if (bus.req_ready !== 4'b1001) begin
            errors++; $display("FAIL wrap_ready got %b want 1001", bus.req_ready); end
        tick();
        checks++; if ({bus.wr1, bus.wr1_data, bus.wr2, bus.wr2_data} !== {2'd3, 16'h3B3B, 2'd0, 16'h0A0A}) begin
            errors++; $display("FAIL wrap_ports got %h want %h", {bus.wr1, bus.wr1_data, bus.wr2, bus.wr2_data}, {2'd3, 16'h3B3B, 2'd0, 16'h0A0A}); end
        r_addr[1] = 2'd1; r_data[1] = 16'h1C1C;
        set_valid(4'b0011);
        tick();
        set_valid(4'b0000);
        // Pointer at 1 puts requester 1 ahead of requester 0.
        checks++; if ({bus.wr1, bus.wr1_data, bus.wr2, bus.wr2_data} !== {2'd1, 16'h1C1C, 2'd0, 16'h0A0A}) begin
            errors++; $display("FAIL wrap_ptr got %h want %h", {bus.wr1, bus.wr1_data, bus.wr2, bus.wr2_data}, {2'd1, 16'h1C1C, 2'd0, 16'h0A0A}); end
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < N; i++) begin
            r_addr[i] = AW'(i);
            r_data[i] = 16'h5000 + DW'(i);
        end
        set_valid(4'b0011);
        tick();
        bus.stall = 1'b1;
        set_valid(4'b1111);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (bus.req_ready !== 4'b0000) begin
                errors++; $display("FAIL stall_ready[%0d] got %b want 0000", c, bus.req_ready); end
            tick();
            checks++; if ({bus.wr1_enable, bus.wr2_enable} !== 2'b00) begin
                errors++; $display("FAIL stall_en[%0d] got %b want 00", c, {bus.wr1_enable, bus.wr2_enable}); end
        end
        bus.stall = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 4'b1100) begin
            errors++; $display("FAIL stall_resume_ready got %b want 1100", bus.req_ready); end
        tick();
        set_valid(4'b0000);
        checks++; if ({bus.wr1, bus.wr1_data, bus.wr2, bus.wr2_data} !== {2'd2, 16'h5002, 2'd3, 16'h5003}) begin
            errors++; $display("FAIL stall_resume_ports got %h want %h", {bus.wr1, bus.wr1_data, bus.wr2, bus.wr2_data}, {2'd2, 16'h5002, 2'd3, 16'h5003}); end
    endtask

    // Builds the circular visiting order from the pointer, then picks the first
    // valid requester and the next valid one aimed at a different register.
    task automatic model_grant(input logic stall, output int a, output int b);
        int order[$];
        a = -1;
        b = -1;
        for (int k = 0; k < N; k++) order.push_back((m_rr + k) % N);
        if (!stall) begin
            foreach (order[j]) begin
                if (r_valid[order[j]]) begin
                    if (a < 0) a = order[j];
                    else if (b < 0 && r_addr[order[j]] != r_addr[a]) b = order[j];
                end
            end
        end
    endtask

    task automatic test_random();
        int           a, b;
        logic [N-1:0] exp_ready;
        logic [3:0]   exp_pend;
        do_reset();
        m_rr  = 0;
        e_en1 = 1'b0; e_wr1 = '0; e_d1 = '0;
        e_en2 = 1'b0; e_wr2 = '0; e_d2 = '0;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!r_valid[i] && ($urandom_range(0, 1) == 1)) begin
                    r_valid[i] = 1'b1;
                    r_addr[i]  = AW'($urandom_range(0, 3));
                    r_data[i]  = DW'($urandom);
                end
            end
            bus.stall = ($urandom_range(0, 7) == 0);
            drive();
            #1;
            model_grant(bus.stall, a, b);
            exp_ready = '0;
            if (a >= 0) exp_ready[a] = 1'b1;
            if (b >= 0) exp_ready[b] = 1'b1;
            checks++; if (bus.req_ready !== exp_ready) begin
                errors++; $display("FAIL rand_ready[%0d] got %b want %b", c, bus.req_ready, exp_ready); end
            if (a >= 0) begin
                e_en1 = 1'b1; e_wr1 = r_addr[a]; e_d1 = r_data[a];
                m_rr  = (((b >= 0) ? b : a) + 1) % N;
            end else begin
                e_en1 = 1'b0;
            end
            if (b >= 0) begin
                e_en2 = 1'b1; e_wr2 = r_addr[b]; e_d2 = r_data[b];
            end else begin
                e_en2 = 1'b0;
            end
            tick();
            checks++; if ({bus.wr1_enable, bus.wr1, bus.wr1_data} !== {e_en1, e_wr1, e_d1}) begin
                errors++; $display("FAIL rand_wr1[%0d] got %h want %h", c, {bus.wr1_enable, bus.wr1, bus.wr1_data}, {e_en1, e_wr1, e_d1}); end
            checks++; if ({bus.wr2_enable, bus.wr2, bus.wr2_data} !== {e_en2, e_wr2, e_d2}) begin
                errors++; $display("FAIL rand_wr2[%0d] got %h want %h", c, {bus.wr2_enable, bus.wr2, bus.wr2_data}, {e_en2, e_wr2, e_d2}); end
            exp_pend = '0;
            if (e_en1) exp_pend[e_wr1] = 1'b1;
            if (e_en2) exp_pend[e_wr2] = 1'b1;
            checks++; if (bus.reg_pending !== exp_pend) begin
                errors++; $display("FAIL rand_pending[%0d] got %b want %b", c, bus.reg_pending, exp_pend); end
            if (a >= 0) r_valid[a] = 1'b0;
            if (b >= 0) r_valid[b] = 1'b0;
        end
        bus.stall = 1'b0;
        set_valid(4'b0000);
    endtask

    initial begin
        bus.stall     = 1'b0;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        test_reset();
        test_two_writes();
        test_conflict();
        test_fairness();
        test_wrap();
        test_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
